fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the RISC-V core, sitting beside the ID stage and steering the operand muxes at the ID/EX boundary. It keeps its own shadow pipeline of destination-register records for the NUM_STAGES instructions downstream of ID. For each source operand it selects the youngest forwarding source, and it raises a stall when that source is a load whose data is not ready yet. It also keeps a saturating count of stall cycles for performance monitoring.

## Interface
- NUM_STAGES, 3, number of tracked downstream stages (entry 1 = EX, 2 = MEM, 3 = WB); legal range 1..7
- LOAD_READY_STAGE, 2, lowest entry index at which a load result is forwardable; legal range 1..NUM_STAGES
- CNT_W, 32, width of the stall counter
- SEL_W (localparam), $clog2(NUM_STAGES+1)
- clk  input  1  core clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- inst_id  input  32  instruction currently in ID
- id_valid  input  1  inst_id holds a real instruction, not a bubble
- flush  input  1  ID instruction is killed this cycle (taken branch or jump resolved downstream)
- rd1_sel  output  SEL_W  rs1 source: 0 = register file, i = shadow entry i
- rd2_sel  output  SEL_W  rs2 source, same encoding as rd1_sel
- stall  output  1  hold IF/ID and insert a bubble into EX
- stall_count  output  CNT_W  saturating count of cycles with stall=1

## Operation
- Decode the ID instruction:
  - opcode = inst[6:0], rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20].
  - has_rd is 1 unless opcode is STORE 0100011, BRANCH 1100011 or SYSTEM 1110011, and is 0 when rd==0.
  - is_load = (opcode == 0000011).
  - uses_rs1 is 0 only for LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - uses_rs2 is 1 only for OP 0110011, STORE and BRANCH.
- Each shadow entry holds {valid, has_rd, rd[4:0], is_load}.
- Every cycle all entries shift: entry i+1 takes entry i, and the last entry drops off.
- Entry 1 loads as follows:
  - Decoded ID record when id_valid && !flush && !stall.
  - Otherwise a bubble (valid = 0).
- Match: entry i matches rsX when valid && has_rd && rd == rsX && rsX != 0 && uses_rsX && id_valid.
- rdX_sel is the smallest matching index i (youngest producer wins), or 0 if nothing matches.
- Hazard: stall = id_valid && !flush && (h1 || h2).
  - hX = the entry chosen for rsX has is_load && index < LOAD_READY_STAGE.
  - Only the youngest match is checked. An older ready copy never hides a younger, unready load.
- Simultaneous flush and hazard: flush wins. stall=0 and a bubble is inserted.
- stall_count increments by 1 in each cycle that stall=1 and saturates at all-ones, with no wrap.
- The unit has no knowledge of downstream stage stalls. The core advances the whole back end every cycle.

## Timing
- Reset (rst_n low, asynchronous): all entries invalid and stall_count = 0, so rd1_sel = rd2_sel = 0 and stall = 0 immediately.
- Reset deasserting mid-stream: the first instruction seen gets no forwarding from pre-reset work.
- rdX_sel and stall are combinational from inst_id, id_valid, flush and the entries. Same-cycle response, no registered latency.
- A record inserted at edge t is entry 1 during cycle t+1 and entry i during cycle t+i. It is gone after NUM_STAGES cycles.
- A load followed immediately by a user stalls for LOAD_READY_STAGE-1 cycles (1 at defaults). After that, rdX_sel points at entry LOAD_READY_STAGE.
- The stall_count update is registered: it reflects a stall one edge later.
- With NUM_STAGES=1, SEL_W=1 and only EX forwarding exists. Any LOAD_READY_STAGE other than 1 is illegal (checked by an initial assertion).

## Test plan
- Reset: assert rst_n=0 mid-stream with entries full. Required: sel=0, stall=0 and stall_count=0 asynchronously, before the next edge.
- Back-to-back ALU: add x5,x1,x2 then sub x6,x5,x5. Required: rd1_sel=rd2_sel=1 and stall=0. With one nop inserted between them, sel=2.
- Youngest wins: addi x7 at t, addi x7 at t+1, then a use of x7 at t+2. Required: sel=1, not 2.
- Load-use: lw x8 then add x9,x8,x0 (defaults). Required: stall=1 for one cycle, then rd1_sel=2 and stall=0. stall_count reads 1 afterwards.
- x0 and format gating: lw x0 followed by use of x0 gives no stall and sel=0. lui x3 followed by an instruction whose rs1 field=3 but opcode JAL gives rd1_sel=0. A store data register matching gives rd2_sel nonzero. A BRANCH preceding never produces a match.
- Flush and saturation: flush=1 together with a load-use hazard gives stall=0 and a bubble in entry 1. With CNT_W=4, hold the hazard for 20 cycles: stall_count stops at 15.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forwarding select and load-use stall generator.
//   The unit shadows the NUM_STAGES instructions downstream of ID (entry 1 = EX)
//   with {valid, has_rd, rd, is_load} records. For each source operand of the
//   ID instruction it picks the youngest matching producer. It stalls when that
//   producer is a load that has not yet reached LOAD_READY_STAGE.
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   inst_id           instruction in ID
//   id_valid          inst_id is a real instruction
//   flush             ID instruction is killed this cycle
//   rd1_sel/rd2_sel   0 = register file, i = shadow entry i
//   stall             hold IF/ID and insert a bubble into EX
//   stall_count       saturating count of stall cycles

// Per-entry comparator: tells whether one shadow record produces rs1/rs2.
module fwd_match (
  input  logic       valid,
  input  logic       has_rd,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use1,
  input  logic       use2,
  input  logic       id_valid,
  output logic       m1,
  output logic       m2
);
  logic live;
  assign live = valid && has_rd && id_valid;
  assign m1   = live && use1 && (rs1 != 5'd0) && (rd == rs1);
  assign m2   = live && use2 && (rs2 != 5'd0) && (rd == rs2);
endmodule

module fwd_hazard_unit #(
  parameter  int NUM_STAGES       = 3,
  parameter  int LOAD_READY_STAGE = 2,
  parameter  int CNT_W            = 32,
  localparam int SEL_W            = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_id,
  input  logic             id_valid,
  input  logic             flush,
  output logic [SEL_W-1:0] rd1_sel,
  output logic [SEL_W-1:0] rd2_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  if (NUM_STAGES < 1 || NUM_STAGES > 7 ||
      LOAD_READY_STAGE < 1 || LOAD_READY_STAGE > NUM_STAGES) begin : g_bad_cfg
    $error("fwd_hazard_unit: illegal NUM_STAGES/LOAD_READY_STAGE");
  end

  typedef struct packed {
    logic       valid;
    logic       has_rd;
    logic [4:0] rd;
    logic       is_load;
  } ent_t;

  // ---- decode ----
  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic       use1, use2;
  ent_t       dec;
  logic       unused;

  assign opc  = inst_id[6:0];
  assign rd   = inst_id[11:7];
  assign rs1  = inst_id[19:15];
  assign rs2  = inst_id[24:20];
  assign use1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  assign use2 = (opc == OP_OP) || (opc == OP_STORE) || (opc == OP_BRANCH);
  assign unused = ^{inst_id[31:25], inst_id[14:12]};

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.has_rd  = !(opc == OP_STORE || opc == OP_BRANCH || opc == OP_SYSTEM) && (rd != 5'd0);
    dec.rd      = rd;
    dec.is_load = (opc == OP_LOAD);
  end

  // ---- shadow pipeline, ent[1] = EX ----
  ent_t [NUM_STAGES:1]      ent;
  logic [NUM_STAGES:1]      m1, m2;

  for (genvar g = 1; g <= NUM_STAGES; g++) begin : g_ent
    fwd_match u_match (
      .valid    (ent[g].valid),
      .has_rd   (ent[g].has_rd),
      .rd       (ent[g].rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .use1     (use1),
      .use2     (use2),
      .id_valid (id_valid),
      .m1       (m1[g]),
      .m2       (m2[g])
    );
  end

  // Scan oldest to youngest so the youngest match overwrites; the load-ready
  // flag travels with the chosen entry so an older ready copy cannot mask it.
  logic h1, h2;
  always_comb begin
    rd1_sel = '0;
    rd2_sel = '0;
    h1      = 1'b0;
    h2      = 1'b0;
    for (int i = NUM_STAGES; i >= 1; i--) begin
      if (m1[i]) begin
        rd1_sel = SEL_W'(i);
        h1      = ent[i].is_load && (i < LOAD_READY_STAGE);
      end
      if (m2[i]) begin
        rd2_sel = SEL_W'(i);
        h2      = ent[i].is_load && (i < LOAD_READY_STAGE);
      end
    end
  end

  // Flush dominates: a killed instruction neither stalls nor enters EX.
  assign stall = id_valid && !flush && (h1 || h2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent         <= '0;
      stall_count <= '0;
    end else begin
      ent[1] <= (id_valid && !flush && !stall) ? dec : '0;
      for (int i = 2; i <= NUM_STAGES; i++) ent[i] <= ent[i-1];
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int N   = 3;
  localparam int LRS = 2;
  localparam int CW  = 4;
  localparam int SW  = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   inst_id = 32'h0;
  logic          id_valid = 1'b0;
  logic          flush = 1'b0;
  logic [SW-1:0] rd1_sel, rd2_sel;
  logic          stall;
  logic [CW-1:0] stall_count;

  fwd_hazard_unit #(.NUM_STAGES(N), .LOAD_READY_STAGE(LRS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .id_valid(id_valid), .flush(flush),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: list of in-flight producers, youngest first ----
  typedef struct { bit v; bit w; int rd; bit ld; } rec_t;
  rec_t hist[1:N];
  int   m_cnt;
  int   e1, e2;
  bit   es;

  function automatic rec_t decode(input logic [31:0] in);
    rec_t r;
    int op = in[6:0];
    r.v  = 1;
    r.rd = in[11:7];
    r.w  = !(op == 'h23 || op == 'h63 || op == 'h73) && r.rd != 0;
    r.ld = (op == 'h03);
    return r;
  endfunction

  task automatic model_clear();
    foreach (hist[i]) hist[i] = '{0, 0, 0, 0};
    m_cnt = 0;
  endtask

  task automatic model_eval(input logic [31:0] in, input bit v, input bit f);
    int op = in[6:0];
    int s1 = in[19:15], s2 = in[24:20];
    bit u1 = !(op == 'h37 || op == 'h17 || op == 'h6f);
    bit u2 = (op == 'h33 || op == 'h23 || op == 'h63);
    e1 = 0; e2 = 0;
    for (int i = 1; i <= N; i++) begin
      if (e1 == 0 && v && u1 && s1 != 0 && hist[i].v && hist[i].w && hist[i].rd == s1) e1 = i;
      if (e2 == 0 && v && u2 && s2 != 0 && hist[i].v && hist[i].w && hist[i].rd == s2) e2 = i;
    end
    es = v && !f && ((e1 != 0 && hist[e1].ld && e1 < LRS) || (e2 != 0 && hist[e2].ld && e2 < LRS));
  endtask

  task automatic model_adv(input logic [31:0] in, input bit v, input bit f);
    for (int i = N; i >= 2; i--) hist[i] = hist[i-1];
    if (v && !f && !es) hist[1] = decode(in);
    else hist[1] = '{0, 0, 0, 0};
    if (es && m_cnt != (1 << CW) - 1) m_cnt++;
  endtask

  task automatic step(input logic [31:0] in, input bit v = 1, input bit f = 0);
    @(negedge clk);
    inst_id = in; id_valid = v; flush = f;
    #1;
    model_eval(in, v, f);
    chk("sel1", rd1_sel, e1);
    chk("sel2", rd2_sel, e2);
    chk("stall", stall, es);
    chk("cnt", stall_count, m_cnt);
    model_adv(in, v, f);
  endtask

  // ---- encoders ----
  function automatic logic [31:0] rtype(input int rd, input int a, input int b);
    return {7'b0, 5'(b), 5'(a), 3'b0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] itype(input logic [6:0] op, input int rd, input int a);
    return {12'h0, 5'(a), 3'b0, 5'(rd), op};
  endfunction
  function automatic logic [31:0] stype(input logic [6:0] op, input int a, input int b, input int imm);
    return {7'b0, 5'(b), 5'(a), 3'b0, 5'(imm), op};
  endfunction

  localparam logic [6:0] ADDI = 7'b0010011, LW = 7'b0000011, LUI = 7'b0110111,
                         JAL = 7'b1101111, SW_ = 7'b0100011, BR = 7'b1100011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    #1;
    chk("rst_sel1", rd1_sel, 0); chk("rst_stall", stall, 0); chk("rst_cnt", stall_count, 0);

    // back-to-back ALU
    step(rtype(5, 1, 2));
    step(rtype(6, 5, 5));
    chk("b2b_sel1", rd1_sel, 1); chk("b2b_sel2", rd2_sel, 1); chk("b2b_stall", stall, 0);
    step(rtype(5, 1, 2));
    step(NOP);
    step(rtype(6, 5, 5));
    chk("gap_sel1", rd1_sel, 2); chk("gap_sel2", rd2_sel, 2);

    // youngest wins
    step(itype(ADDI, 7, 0));
    step(itype(ADDI, 7, 0));
    step(rtype(8, 7, 0));
    chk("young_sel1", rd1_sel, 1);

    // load-use
    step(itype(LW, 8, 0));
    step(rtype(9, 8, 0));
    chk("lu_stall", stall, 1); chk("lu_sel1", rd1_sel, 1);
    step(rtype(9, 8, 0));
    chk("lu_stall2", stall, 0); chk("lu_sel1b", rd1_sel, 2); chk("lu_cnt", stall_count, 1);

    // x0 / format gating
    step(itype(LW, 0, 0));
    step(rtype(1, 0, 0));
    chk("x0_stall", stall, 0); chk("x0_sel1", rd1_sel, 0);
    step({20'h0, 5'd3, LUI});
    step({7'b0, 5'd0, 5'd3, 3'b0, 5'd1, JAL});
    chk("jal_sel1", rd1_sel, 0);
    step(itype(ADDI, 4, 0));
    step(stype(SW_, 0, 4, 0));
    chk("st_sel2", rd2_sel, 1);
    step(stype(BR, 1, 2, 5));
    step(rtype(1, 5, 0));
    chk("br_sel1", rd1_sel, 0);

    // flush beats hazard, bubble enters
    step(itype(LW, 10, 0));
    step(rtype(11, 10, 0), 1, 1);
    chk("fl_stall", stall, 0);
    step(rtype(12, 11, 10));
    chk("fl_bubble", rd1_sel, 0); chk("fl_sel2", rd2_sel, 2); chk("fl_stall2", stall, 0);

    // saturation: 20 load-use stalls
    for (int k = 0; k < 20; k++) begin
      step(itype(LW, 14, 0));
      step(rtype(15, 14, 0));
      step(rtype(15, 14, 0));
    end
    step(NOP);
    chk("sat_cnt", stall_count, 15);

    // random
    for (int k = 0; k < 400; k++) begin
      logic [31:0] r = $urandom;
      r[6:0]   = ops[$urandom_range(0, 8)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      step(r, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
    end

    // asynchronous reset mid-stream
    step(itype(ADDI, 5, 0));
    step(itype(LW, 6, 0));
    @(negedge clk);
    inst_id = rtype(7, 5, 6); id_valid = 1; flush = 0;
    #1;
    chk("pre_rst_stall", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sel1", rd1_sel, 0); chk("arst_sel2", rd2_sel, 0);
    chk("arst_stall", stall, 0); chk("arst_cnt", stall_count, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(rtype(7, 5, 6));
    chk("post_rst_sel1", rd1_sel, 0);
    for (int k = 0; k < 50; k++) begin
      logic [31:0] r = $urandom;
      r[6:0]   = ops[$urandom_range(0, 8)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      step(r, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
